// File: rtl/mealy_fsm_pkg.sv
// mealy_fsm_pkg
// Shared definitions for the 4-state Mealy encoder/decoder pair.
//   state_t : 2-bit tracked encoder state, S0..S3 = 0..3
//   dec_t   : decode result {d, next}
//   decode(): (state, encoded bit) -> {original bit, next state};
//             also used by the encoder's verification model.
package mealy_fsm_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  typedef struct packed {
    logic   d;
    state_t next;
  } dec_t;

  function automatic dec_t decode(input state_t s, input logic in_bit);
    dec_t r;
    // Only S1 transmits the inverted bit.
    r.d = (s == S1) ? ~in_bit : in_bit;
    case (s)
      S0, S1:  r.next = r.d ? S2 : S0;
      S2:      r.next = r.d ? S3 : S2;
      default: r.next = r.d ? S1 : S3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mealy_bit_packer.sv
// mealy_bit_packer
// Groups decoded bits into bytes, MSB first.
// Ports:
//   clk        : rising-edge clock
//   Reset      : asynchronous active-high reset
//   Clear      : synchronous flush of the partial byte (byte_out holds)
//   bit_valid  : bit_in carries a decoded bit this cycle
//   bit_in     : decoded bit
//   byte_out   : last completed byte
//   byte_valid : one-cycle pulse when byte_out is loaded
module mealy_bit_packer (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  logic [2:0] r_count;
  logic [7:0] r_shift;
  logic [7:0] r_byte;
  logic       r_byte_valid;
  logic [7:0] w_shift_nxt;

  assign w_shift_nxt = {r_shift[6:0], bit_in};

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_count      <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
    end else if (Clear) begin
      r_count      <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (bit_valid) begin
        r_shift <= w_shift_nxt;
        r_count <= r_count + 3'd1;   // wraps to 0 after the 8th bit
        if (r_count == 3'd7) begin
          r_byte       <= w_shift_nxt;
          r_byte_valid <= 1'b1;
        end
      end
    end
  end

  assign byte_out   = r_byte;
  assign byte_valid = r_byte_valid;

endmodule

// File: rtl/mealy_fsm_decoder.sv
// mealy_fsm_decoder
// Tracks the 4-state Mealy encoder in lockstep and recovers the original
// bit on every valid beat (1-cycle registered latency).
// Ports:
//   clk        : rising-edge clock
//   Reset      : asynchronous active-high reset
//   Clear      : synchronous resync to S0, flushes packer, beat discarded
//   In_valid   : In carries an encoded bit
//   In         : encoded bit
//   out        : decoded bit (holds between beats)
//   out_valid  : one-cycle pulse per decoded bit
//   State      : tracked encoder state
//   byte_out   : packed byte, MSB first (0 without packer)
//   byte_valid : byte pulse, coincident with the 8th out_valid (0 without packer)
// Build option: define MEALY_DEC_PACKER_EN to include the byte packer.
module mealy_fsm_decoder (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       In_valid,
  input  logic       In,
  output logic       out,
  output logic       out_valid,
  output logic [1:0] State,
  output logic [7:0] byte_out,
  output logic       byte_valid
);
  import mealy_fsm_pkg::*;

  state_t r_state;
  state_t w_next;
  dec_t   w_dec;
  logic   w_accept;
  logic   w_d;
  logic   r_out;
  logic   r_out_valid;

  assign w_dec = decode(r_state, In);

  // State register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= S0;
    else       r_state <= w_next;
  end

  // Next-state logic; Clear outranks a valid beat
  always_comb begin
    w_next = r_state;
    if (Clear)         w_next = S0;
    else if (In_valid) w_next = w_dec.next;
  end

  // Mealy output logic
  always_comb begin
    w_accept = In_valid & ~Clear;
    w_d      = w_dec.d;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) r_out <= w_d;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign State     = r_state;

`ifdef MEALY_DEC_PACKER_EN
  // Fed from the pre-register decode so the byte pulse lines up with the
  // 8th out_valid rather than trailing it by a cycle.
  mealy_bit_packer u_packer (
    .clk        (clk),
    .Reset      (Reset),
    .Clear      (Clear),
    .bit_valid  (w_accept),
    .bit_in     (w_d),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );
`else
  assign byte_out   = '0;
  assign byte_valid = 1'b0;
`endif

endmodule
